// File: rtl/uart_bridge_master.sv
// uart_bridge_master: polls up to four UART-Lite channels over one AXI4-Lite
// master port. Received bytes are packed into words and written to a
// per-channel GPIO register, with optional echo and an idle flush timeout.
module uart_bridge_master #(
    parameter int unsigned FREQ_HZ        = 100000000,
    parameter int unsigned NUM_UARTS      = 2,
    parameter logic [31:0] UART_BASE      = 32'h4060_0000,
    parameter logic [31:0] UART_STRIDE    = 32'h0001_0000,
    parameter logic [31:0] GPIO_BASE      = 32'h4000_0000,
    parameter logic [31:0] GPIO_STRIDE    = 32'h0000_0008,
    parameter int unsigned BYTES_PER_WORD = 1,
    parameter int unsigned ECHO           = 0,
    parameter int unsigned FLUSH_US       = 1000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [31:0] M_AXI_AWADDR,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    input  logic [1:0]  M_AXI_BRESP,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,
    output logic [31:0] M_AXI_ARADDR,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY,
    output logic [31:0] rx_count,
    output logic [15:0] err_count,
    output logic        busy
);

    localparam logic [31:0] FLUSH_CYC = 32'(FLUSH_US * (FREQ_HZ / 1000000));
    localparam logic [2:0]  BPW       = 3'(BYTES_PER_WORD);
    localparam logic [1:0]  CH_LAST   = 2'(NUM_UARTS - 1);

    // State names carry an S_ prefix because ECHO is also a parameter name.
    typedef enum logic [3:0] {
        S_POLL, S_POLL_W, S_RXRD, S_RXRD_W, S_ECHO, S_ECHO_W, S_GPIO, S_GPIO_W, S_NEXT
    } state_t;

    state_t      state_q;
    logic [1:0]  ch_q, ch_d;
    logic        tx_full_q;
    logic [7:0]  byte_q;
    logic [31:0] pack_word_q [4];
    logic [2:0]  pack_cnt_q  [4];
    logic [31:0] idle_q      [4];

    logic [31:0] awaddr_q, wdata_q, araddr_q, rx_count_q;
    logic        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q, busy_q;
    logic [15:0] err_count_q, err_inc;

    logic [31:0] uart_base, gpio_addr, lane_word;
    logic [2:0]  cur_cnt, cnt_inc;
    logic        flush_due, rd_done, rd_err, wr_done, wr_err, rx_take;
    logic        unused_rdata;

    assign unused_rdata = ^M_AXI_RDATA[31:8];

    // Address, packing and decision helpers for the current channel.
    always_comb begin
        uart_base = UART_BASE + UART_STRIDE * {30'b0, ch_q};
        gpio_addr = GPIO_BASE + GPIO_STRIDE * {30'b0, ch_q};
        cur_cnt   = pack_cnt_q[ch_q];
        cnt_inc   = cur_cnt + 3'd1;
        flush_due = (FLUSH_US != 0) && (cur_cnt != 3'd0) && (idle_q[ch_q] >= FLUSH_CYC);
        lane_word = pack_word_q[ch_q] | ({24'h0, M_AXI_RDATA[7:0]} << {cur_cnt[1:0], 3'b000});
        rd_done   = M_AXI_RVALID && rready_q;
        rd_err    = M_AXI_RRESP != 2'b00;
        wr_done   = M_AXI_BVALID && bready_q;
        wr_err    = M_AXI_BRESP != 2'b00;
        rx_take   = (state_q == S_RXRD_W) && rd_done && !rd_err;
        err_inc   = (err_count_q == '1) ? err_count_q : err_count_q + 16'd1;
        ch_d      = (ch_q == CH_LAST) ? 2'd0 : ch_q + 2'd1;
    end

    // Per-channel idle timers: count every cycle, saturate, clear on a byte read.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (!resetn) begin
                idle_q[i] <= '0;
            end else if (rx_take && (ch_q == 2'(i))) begin
                idle_q[i] <= '0;
            end else if (idle_q[i] != '1) begin
                idle_q[i] <= idle_q[i] + 32'd1;
            end
        end
    end

    // Bridge FSM with registered AXI outputs; one transaction in flight at a time.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_POLL;
            ch_q        <= '0;
            tx_full_q   <= 1'b0;
            byte_q      <= '0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            araddr_q    <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            busy_q      <= 1'b0;
            rx_count_q  <= '0;
            err_count_q <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                pack_word_q[i] <= '0;
                pack_cnt_q[i]  <= '0;
            end
        end else begin
            if (arvalid_q && M_AXI_ARREADY) arvalid_q <= 1'b0;
            if (awvalid_q && M_AXI_AWREADY) awvalid_q <= 1'b0;
            if (wvalid_q && M_AXI_WREADY)   wvalid_q  <= 1'b0;
            case (state_q)
                S_POLL, S_RXRD: begin
                    araddr_q  <= (state_q == S_POLL) ? uart_base + 32'h8 : uart_base;
                    arvalid_q <= 1'b1;
                    rready_q  <= 1'b1;
                    busy_q    <= 1'b1;
                    state_q   <= (state_q == S_POLL) ? S_POLL_W : S_RXRD_W;
                end
                S_POLL_W: begin
                    if (rd_done) begin
                        rready_q <= 1'b0;
                        busy_q   <= 1'b0;
                        if (rd_err) begin
                            err_count_q <= err_inc;
                            state_q     <= S_NEXT;
                        end else if (M_AXI_RDATA[0]) begin
                            tx_full_q <= M_AXI_RDATA[3];
                            state_q   <= S_RXRD;
                        end else if (flush_due) begin
                            state_q <= S_GPIO;
                        end else begin
                            state_q <= S_NEXT;
                        end
                    end
                end
                S_RXRD_W: begin
                    if (rd_done) begin
                        rready_q <= 1'b0;
                        busy_q   <= 1'b0;
                        if (rd_err) begin
                            err_count_q <= err_inc;
                            state_q     <= S_NEXT;
                        end else begin
                            pack_word_q[ch_q] <= lane_word;
                            pack_cnt_q[ch_q]  <= cnt_inc;
                            rx_count_q        <= rx_count_q + 32'd1;
                            byte_q            <= M_AXI_RDATA[7:0];
                            if ((ECHO != 0) && !tx_full_q) state_q <= S_ECHO;
                            else if (cnt_inc == BPW)       state_q <= S_GPIO;
                            else                           state_q <= S_NEXT;
                        end
                    end
                end
                S_ECHO, S_GPIO: begin
                    awaddr_q  <= (state_q == S_ECHO) ? uart_base + 32'h4 : gpio_addr;
                    wdata_q   <= (state_q == S_ECHO) ? {24'h0, byte_q} : pack_word_q[ch_q];
                    awvalid_q <= 1'b1;
                    wvalid_q  <= 1'b1;
                    bready_q  <= 1'b1;
                    busy_q    <= 1'b1;
                    state_q   <= (state_q == S_ECHO) ? S_ECHO_W : S_GPIO_W;
                end
                S_ECHO_W: begin
                    if (wr_done) begin
                        bready_q <= 1'b0;
                        busy_q   <= 1'b0;
                        if (wr_err) err_count_q <= err_inc;
                        state_q <= (cur_cnt == BPW) ? S_GPIO : S_NEXT;
                    end
                end
                S_GPIO_W: begin
                    if (wr_done) begin
                        bready_q          <= 1'b0;
                        busy_q            <= 1'b0;
                        pack_cnt_q[ch_q]  <= '0;
                        pack_word_q[ch_q] <= '0;
                        if (wr_err) err_count_q <= err_inc;
                        state_q <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    ch_q    <= ch_d;
                    state_q <= S_POLL;
                end
                default: state_q <= S_POLL;
            endcase
        end
    end

    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;
    assign rx_count      = rx_count_q;
    assign err_count     = err_count_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_uart_bridge_master.sv
// Bench for uart_bridge_master: behavioural AXI4-Lite slave emulating two
// UART-Lite channels and the GPIO registers, with a write/read scoreboard.
`timescale 1ns/1ps
module tb_uart_bridge_master;

    localparam logic [31:0] UB = 32'h4060_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] awaddr, wdata, araddr, rdata, rx_count;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, busy;
    logic [1:0]  bresp, rresp;
    logic [15:0] err_count;

    uart_bridge_master #(
        .FREQ_HZ(100000000), .NUM_UARTS(2), .BYTES_PER_WORD(4), .ECHO(1), .FLUSH_US(1)
    ) dut (
        .clk(clk), .resetn(resetn),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
        .rx_count(rx_count), .err_count(err_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_rx_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] addr; logic [31:0] data; int min_gap; } wexp_t;
    wexp_t      exp_w[$];
    int         exp_rx[$];
    logic [7:0] rxq0[$];
    logic [7:0] rxq1[$];

    logic [1:0] tx_full = 2'b00;
    logic [1:0] stat_err = 2'b00;
    logic       err_stat_next = 1'b0;
    logic       bresp_err_next = 1'b0;
    int         aw_delay = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_rx(input int ch, input logic [7:0] b);
        if (ch == 0) rxq0.push_back(b);
        else         rxq1.push_back(b);
        exp_rx.push_back(ch);
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d, input int gap);
        wexp_t e;
        e.addr = a; e.data = d; e.min_gap = gap;
        exp_w.push_back(e);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((exp_w.size() != 0 || exp_rx.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(exp_w.size() + exp_rx.size()), 64'd0);
    endtask

    task automatic wait_ar(input logic [31:0] a, input int budget);
        int n = 0;
        while (!(arvalid === 1'b1 && araddr === a) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_ar", {63'd0, n < budget}, 64'd1);
    endtask

    // AXI4-Lite slave state; handshakes are resolved from the values held
    // across the posedge between two negedges.
    logic        s_arv, s_rr, s_awv, s_wv, s_br;
    logic [31:0] s_araddr, s_awaddr, s_wdata, wr_addr, wr_data;
    logic [3:0]  s_wstrb;
    logic        ar_hs, r_hs, aw_hs, w_hs, b_hs, aw_done, w_done;
    int          aw_cnt, c, e_ch;
    logic [3:0]  off;
    wexp_t       we;

    always @(negedge clk) begin
        if (!resetn) begin
            arready = 0; rvalid = 0; rdata = '0; rresp = '0;
            awready = 0; wready = 0; bvalid = 0; bresp = '0;
            aw_done = 0; w_done = 0; aw_cnt = 0;
            s_arv = 0; s_rr = 0; s_awv = 0; s_wv = 0; s_br = 0;
        end else begin
            ar_hs = s_arv && arready;
            r_hs  = rvalid && s_rr;
            aw_hs = s_awv && awready;
            w_hs  = s_wv && wready;
            b_hs  = bvalid && s_br;

            if (s_arv && !arready) chk("ar_hold", {31'd0, arvalid, araddr}, {31'd0, 1'b1, s_araddr});
            if (s_awv && !awready) chk("aw_hold", {31'd0, awvalid, awaddr}, {31'd0, 1'b1, s_awaddr});
            if (s_wv && !wready)   chk("w_hold", {31'd0, wvalid, wdata}, {31'd0, 1'b1, s_wdata});
            if (s_rr && !rvalid)   chk("rready_hold", {63'd0, rready}, 64'd1);
            if (s_br && !bvalid)   chk("bready_hold", {63'd0, bready}, 64'd1);
            if (ar_hs) chk("ar_drop", {63'd0, arvalid}, 64'd0);
            if (aw_hs) chk("aw_drop", {63'd0, awvalid}, 64'd0);
            if (w_hs)  chk("w_drop", {63'd0, wvalid}, 64'd0);
            if (w_hs)  chk("wstrb", {60'd0, s_wstrb}, 64'hF);
            if (arvalid || rready || awvalid || wvalid || bready) begin
                chk("busy_when_active", {63'd0, busy}, 64'd1);
                chk("one_outstanding", {63'd0, (arvalid || rready) && (awvalid || wvalid || bready)}, 64'd0);
            end

            if (r_hs) rvalid = 0;
            if (ar_hs) begin
                c     = int'(s_araddr[16]);
                off   = s_araddr[3:0];
                rresp = 2'b00;
                rdata = '0;
                chk("rd_addr_decode", {62'd0, (s_araddr & ~32'h0001_000F) == UB, off == 4'h0 || off == 4'h8}, 64'd3);
                if (off == 4'h8) begin
                    rdata = {28'h0, tx_full[c], 2'b00, (c == 0) ? rxq0.size() != 0 : rxq1.size() != 0};
                    if (c == 0 && err_stat_next) begin
                        rresp = 2'b10; err_stat_next = 0; stat_err[0] = 1'b1;
                    end else begin
                        stat_err[c] = 1'b0;
                    end
                end else if (off == 4'h0) begin
                    chk("rx_after_err", {63'd0, stat_err[c]}, 64'd0);
                    checks++;
                    assert (exp_rx.size() != 0) else begin
                        failures++;
                        $error("FAIL rx_unexpected: observed read of ch%0d expected none", c);
                    end
                    if (exp_rx.size() != 0) begin
                        e_ch = exp_rx.pop_front();
                        chk("rx_order", 64'(c), 64'(e_ch));
                    end
                    if (c == 0 && rxq0.size() != 0) rdata = {24'h0, rxq0.pop_front()};
                    if (c == 1 && rxq1.size() != 0) rdata = {24'h0, rxq1.pop_front()};
                    last_rx_cyc = cyc;
                end
                rvalid = 1;
            end
            arready = arvalid && !rvalid;

            if (b_hs) begin bvalid = 0; aw_done = 0; w_done = 0; aw_cnt = 0; end
            if (aw_hs) begin aw_done = 1; wr_addr = s_awaddr; end
            if (w_hs)  begin w_done = 1;  wr_data = s_wdata;  end
            if (aw_done && w_done && !bvalid) begin
                bvalid = 1;
                bresp = bresp_err_next ? 2'b10 : 2'b00;
                bresp_err_next = 0;
                checks++;
                assert (exp_w.size() != 0) else begin
                    failures++;
                    $error("FAIL wr_unexpected: observed addr=%h data=%h expected none", wr_addr, wr_data);
                end
                if (exp_w.size() != 0) begin
                    we = exp_w.pop_front();
                    chk("wr_addr", {32'd0, wr_addr}, {32'd0, we.addr});
                    chk("wr_data", {32'd0, wr_data}, {32'd0, we.data});
                    if (we.min_gap > 0) chk("flush_gap", {63'd0, (cyc - last_rx_cyc) >= we.min_gap}, 64'd1);
                end
            end
            if (w_done && !aw_done) aw_cnt++;
            wready  = wvalid && !w_done;
            awready = awvalid && !aw_done && (aw_delay == 0 || (w_done && aw_cnt >= aw_delay));

            s_arv = arvalid; s_araddr = araddr; s_rr = rready;
            s_awv = awvalid; s_awaddr = awaddr; s_wv = wvalid; s_wdata = wdata;
            s_wstrb = wstrb; s_br = bready;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a, b;
        resetn = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_arvalid", {63'd0, arvalid}, 64'd0);
        chk("rst_rready", {63'd0, rready}, 64'd0);
        chk("rst_awvalid", {63'd0, awvalid}, 64'd0);
        chk("rst_wvalid", {63'd0, wvalid}, 64'd0);
        chk("rst_bready", {63'd0, bready}, 64'd0);
        chk("rst_araddr", {32'd0, araddr}, 64'd0);
        chk("rst_awaddr", {32'd0, awaddr}, 64'd0);
        chk("rst_wdata", {32'd0, wdata}, 64'd0);
        chk("rst_rx_count", {32'd0, rx_count}, 64'd0);
        chk("rst_err_count", {48'd0, err_count}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        resetn = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_rx_count", {32'd0, rx_count}, 64'd0);

        // Single byte with echo, then flushed as a partial word.
        push_rx(0, 8'h5A);
        exp_wr(32'h4060_0004, 32'h0000_005A, 0);
        exp_wr(32'h4000_0000, 32'h0000_005A, 100);
        wait_drain("drain_echo", 2000);
        chk("rx_count_echo", {32'd0, rx_count}, 64'd1);

        // TX full: echo skipped, byte still flushed after the idle time.
        tx_full[0] = 1'b1;
        push_rx(0, 8'h7E);
        exp_wr(32'h4000_0000, 32'h0000_007E, 100);
        wait_drain("drain_txfull", 2000);
        chk("rx_count_txfull", {32'd0, rx_count}, 64'd2);
        tx_full[0] = 1'b0;

        // Both channels loaded with full words: strict alternation.
        wait_ar(UB + 32'h8, 200);
        for (int i = 0; i < 4; i++) begin
            a = 8'(8'h11 * (i + 1));
            b = 8'(8'hA0 + i);
            push_rx(0, a);
            push_rx(1, b);
            exp_wr(32'h4060_0004, {24'h0, a}, 0);
            if (i == 3) exp_wr(32'h4000_0000, 32'h4433_2211, 0);
            exp_wr(32'h4061_0004, {24'h0, b}, 0);
            if (i == 3) exp_wr(32'h4000_0008, 32'hA3A2_A1A0, 0);
        end
        wait_drain("drain_rr", 3000);
        repeat (300) @(negedge clk);
        chk("rx_count_rr", {32'd0, rx_count}, 64'd10);
        chk("no_extra_writes", 64'(exp_w.size()), 64'd0);

        // STATUS read error discards RX-valid; echo write error is counted only.
        wait_ar(UB + 32'h8, 200);
        aw_delay = 5;
        err_stat_next = 1'b1;
        bresp_err_next = 1'b1;
        push_rx(0, 8'h99);
        exp_wr(32'h4060_0004, 32'h0000_0099, 0);
        exp_wr(32'h4000_0000, 32'h0000_0099, 100);
        for (int n = 0; n < 500 && exp_rx.size() != 0; n++) @(negedge clk);
        chk("err_count_rd", {48'd0, err_count}, 64'd1);
        wait_drain("drain_err", 3000);
        chk("err_count_wr", {48'd0, err_count}, 64'd2);
        chk("rx_count_err", {32'd0, rx_count}, 64'd11);
        aw_delay = 0;

        // Reset in the middle of a read abandons it at once.
        wait_ar(UB + 32'h8, 200);
        resetn = 1'b0;
        @(negedge clk);
        chk("midrst_arvalid", {63'd0, arvalid}, 64'd0);
        chk("midrst_rready", {63'd0, rready}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_rx_count", {32'd0, rx_count}, 64'd0);
        chk("midrst_err_count", {48'd0, err_count}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
